// File: rtl/bram_port_ctrl.sv
// ---------------------------------------------------------------------------
// bram_port_ctrl
//   Fabric-side initiator for the 1 KB dual-port BlockRAM primitive.
//   Converts independent valid/ready write and read request channels into
//   the RAM's packed pin encoding. Write data, write-address lane bits,
//   dynamic write enable and read-address lane bits all share the RAM's
//   32-bit write-data bus. Read data is captured after the fixed RAM latency
//   and held in a first-word-fall-through response FIFO. Reads are only
//   issued while a FIFO slot is guaranteed, so the FIFO cannot overflow.
//
// Optional feature (compile-time macro BRAM_WR_BYPASS_EN):
//   defined   - a read that hits the address being written in the same cycle
//               is accepted anyway; the write data travels with the read
//               token and replaces the RAM output when the response is stored.
//   undefined - such a read is held off for one cycle and issues afterwards.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   wr_valid/wr_ready          write request handshake
//   wr_addr[9:0], wr_data[15:0] write address / data
//   rd_valid/rd_ready          read request handshake
//   rd_addr[9:0]               read address
//   rsp_valid/rsp_ready        response handshake
//   rsp_data[15:0]             response data (zero-extended when MODE=2)
//   ram_wr_addr[7:0]           RAM write-port row address
//   ram_rd_addr[7:0]           RAM read-port row address
//   ram_wr_data[31:0]          packed RAM write bus
//   ram_rd_data[31:0]          RAM read data, lane already selected
// ---------------------------------------------------------------------------
module bram_port_ctrl #(
  parameter int MODE          = 1,
  parameter int RD_REG        = 0,
  parameter int RSP_DEPTH     = 4,
  parameter int READ_MSB_POS  = 24,
  parameter int WRITE_MSB_POS = 16,
  parameter int WE_POS        = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [9:0]  rd_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [7:0]  ram_wr_addr,
  output logic [7:0]  ram_rd_addr,
  output logic [31:0] ram_wr_data,
  input  logic [31:0] ram_rd_data
);

  localparam int LAT = RD_REG + 1;          // read-token pipeline stages
  localparam int PW  = $clog2(RSP_DEPTH);   // FIFO pointer width

  function automatic logic [7:0] row_of(input logic [9:0] a);
    return (MODE == 1) ? a[8:1] : a[9:2];
  endfunction

  function automatic logic [1:0] lane_of(input logic [9:0] a);
    return (MODE == 1) ? {1'b0, a[0]} : a[1:0];
  endfunction

  // Narrow a 16-bit word to the configured port width.
  function automatic logic [15:0] port_word(input logic [15:0] d);
    return (MODE == 1) ? d : {8'h00, d[7:0]};
  endfunction

  logic            wr_fire, rd_fire, collision, same_addr;
  logic            push, pop;
  logic [15:0]     push_data;
  logic [LAT-1:0]  tok;
  logic [PW:0]     occ;
  logic [PW+1:0]   infl, used;
  logic [PW-1:0]   wptr, rptr;
  logic [15:0]     fifo [RSP_DEPTH];

  // Upper RAM read lanes carry nothing this block needs.
  logic unused_rd_hi;
  assign unused_rd_hi = ^ram_rd_data[31:16];

  // ---------------- request side ----------------
  assign same_addr = (MODE == 1) ? (wr_addr[8:0] == rd_addr[8:0]) : (wr_addr == rd_addr);
  assign collision = wr_valid && rd_valid && same_addr;

  // Credits cover both stored responses and reads still inside the RAM.
  always_comb begin
    // NOTE: blocking assignments are correct here; this is combinational
    // logic and every output gets a default before any conditional update.
    infl = '0;
    for (int i = 0; i < LAT; i++) infl = infl + (PW+2)'(tok[i]);
  end
  assign used = {1'b0, occ} + infl;

  assign wr_ready = !rst;
`ifdef BRAM_WR_BYPASS_EN
  assign rd_ready = !rst && (used < (PW+2)'(RSP_DEPTH));
`else
  assign rd_ready = !rst && (used < (PW+2)'(RSP_DEPTH)) && !collision;
`endif
  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = rd_valid && rd_ready;

  assign ram_wr_addr = row_of(wr_addr);
  assign ram_rd_addr = row_of(rd_addr);

  always_comb begin
    ram_wr_data                        = '0;
    ram_wr_data[15:0]                  = port_word(wr_data);
    ram_wr_data[WRITE_MSB_POS +: 2]    = lane_of(wr_addr);
    ram_wr_data[READ_MSB_POS +: 2]     = lane_of(rd_addr);
    ram_wr_data[WE_POS]                = wr_fire;
  end

  // ---------------- read latency tracking ----------------
  // tok[LAT-1] marks the edge at which ram_rd_data holds the response.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      tok <= '0;
    end else begin
      tok[0] <= rd_fire;
      for (int i = 1; i < LAT; i++) tok[i] <= tok[i-1];
    end
  end

`ifdef BRAM_WR_BYPASS_EN
  // Write data rides alongside the read token so a colliding read returns
  // the value written in the same cycle.
  logic [LAT-1:0] byp_hit;
  logic [15:0]    byp_dat [LAT];

  always_ff @(posedge clk) begin
    byp_hit[0] <= rd_fire && collision;
    byp_dat[0] <= port_word(wr_data);
    for (int i = 1; i < LAT; i++) begin
      byp_hit[i] <= byp_hit[i-1];
      byp_dat[i] <= byp_dat[i-1];
    end
  end
`endif

  always_comb begin
    push_data = port_word(ram_rd_data[15:0]);
`ifdef BRAM_WR_BYPASS_EN
    if (byp_hit[LAT-1]) push_data = byp_dat[LAT-1];
`endif
  end

  // ---------------- response FIFO (first-word fall-through) ----------------
  assign push      = tok[LAT-1];
  assign rsp_valid = (occ != '0);
  assign rsp_data  = fifo[rptr];
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy and pointers
  // decide what is valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= push_data;
  end

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Testbench for bram_port_ctrl. Two instances share clk/rst:
//   lane 0: MODE=2 (8-bit port), RD_REG=0
//   lane 1: MODE=1 (16-bit port), RD_REG=1
// Each lane has a behavioural BlockRAM that decodes the packed write bus.
// Stimulus pushes hand-computed expected read data into a per-lane queue;
// a per-lane monitor pops and compares on every response handshake.
module tb_bram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid [2];
  logic        wr_ready [2];
  logic [9:0]  wr_addr  [2];
  logic [15:0] wr_data  [2];
  logic        rd_valid [2];
  logic        rd_ready [2];
  logic [9:0]  rd_addr  [2];
  logic        rsp_valid[2];
  logic        rsp_ready[2];
  logic [15:0] rsp_data [2];
  logic [7:0]  ram_wr_addr[2];
  logic [7:0]  ram_rd_addr[2];
  logic [31:0] ram_wr_data[2];
  logic [31:0] ram_rd_data[2];

  int total = 0;
  int bad   = 0;
  logic [15:0] exq0[$];
  logic [15:0] exq1[$];
  int outstanding[2];
  bit overflow_seen = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? exq0.size() : exq1.size();
  endfunction

  task automatic sb_push(input int k, input logic [15:0] v);
    if (k == 0) exq0.push_back(v);
    else        exq1.push_back(v);
  endtask

  task automatic sb_check(input int k, input logic [15:0] act);
    logic [15:0] e;
    if (qsize(k) == 0) begin
      total++;
      bad++;
      $display("FAIL rsp_unexpected lane%0d: got 0x%0h with nothing outstanding", k, act);
    end else begin
      if (k == 0) e = exq0.pop_front();
      else        e = exq1.pop_front();
      check($sformatf("rsp_data lane%0d", k), act, e);
    end
  endtask

  // ---------------- DUTs, RAM models, monitors ----------------
  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int GM = (g == 0) ? 2 : 1;
    localparam int GR = g;

    bram_port_ctrl #(.MODE(GM), .RD_REG(GR), .RSP_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid[g]),
      .wr_ready   (wr_ready[g]),
      .wr_addr    (wr_addr[g]),
      .wr_data    (wr_data[g]),
      .rd_valid   (rd_valid[g]),
      .rd_ready   (rd_ready[g]),
      .rd_addr    (rd_addr[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_data   (rsp_data[g]),
      .ram_wr_addr(ram_wr_addr[g]),
      .ram_rd_addr(ram_rd_addr[g]),
      .ram_wr_data(ram_wr_data[g]),
      .ram_rd_data(ram_rd_data[g])
    );

    // Behavioural BlockRAM: read-first, one cycle latency plus optional
    // output register; unrelated bus bits are filled with junk.
    logic [15:0] mem [0:1023];
    logic [15:0] q1, q2, rq, wdat;
    logic [31:0] wd;
    logic [9:0]  widx, ridx;

    always_comb begin
      wd   = ram_wr_data[g];
      widx = (GM == 1) ? {1'b0, ram_wr_addr[g], wd[16]} : {ram_wr_addr[g], wd[17:16]};
      ridx = (GM == 1) ? {1'b0, ram_rd_addr[g], wd[24]} : {ram_rd_addr[g], wd[25:24]};
      wdat = (GM == 1) ? wd[15:0] : {8'h00, wd[7:0]};
      rq   = (GR == 1) ? q2 : q1;
    end

    always @(posedge clk) begin
      q1 <= mem[ridx];
      q2 <= q1;
      if (wd[20]) mem[widx] <= wdat;
    end

    assign ram_rd_data[g] = {16'hDEAD, (GM == 2) ? {8'hC3, rq[7:0]} : rq};

    always @(negedge clk) begin
      if (rst) outstanding[g] = 0;
      else begin
        if (rd_valid[g] && rd_ready[g]) outstanding[g]++;
        if (rsp_valid[g] && rsp_ready[g]) begin
          outstanding[g]--;
          sb_check(g, rsp_data[g]);
        end
        if (outstanding[g] > 4) overflow_seen = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input int k, input logic [9:0] a, input logic [15:0] d);
    wr_valid[k] = 1'b1; wr_addr[k] = a; wr_data[k] = d;
    @(posedge clk); #1;
    wr_valid[k] = 1'b0;
  endtask

  task automatic do_read(input int k, input logic [9:0] a, input logic [15:0] e);
    bit done = 1'b0;
    rd_valid[k] = 1'b1; rd_addr[k] = a;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (rd_ready[k]) begin
        sb_push(k, e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    rd_valid[k] = 1'b0;
    check($sformatf("rd_accept lane%0d addr 0x%0h", k, a), done, 1);
  endtask

  // Counts negedges after a read was accepted; rsp_valid must rise on the
  // lat-th one and not before.
  task automatic expect_first_rsp(input int k, input int lat, input string nm);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      check($sformatf("%s rsp_valid c%0d", nm, i), rsp_valid[k], (i == lat));
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int k, input string nm);
    for (int t = 0; t < 60 && qsize(k) != 0; t++) @(posedge clk);
    check($sformatf("%s drained", nm), qsize(k), 0);
    @(negedge clk);
    check($sformatf("%s idle", nm), rsp_valid[k], 0);
    @(posedge clk); #1;
  endtask

  // Holds a read request for n cycles and returns how many were accepted.
  task automatic stream_reads(input int k, input int n, input logic [9:0] base,
                              input logic [15:0] dbase, inout int n_acc, input int limit);
    for (int c = 0; c < n && n_acc < limit; c++) begin
      rd_valid[k] = 1'b1;
      rd_addr[k]  = base + 10'(n_acc);
      @(negedge clk);
      if (rd_ready[k]) begin
        sb_push(k, dbase + 16'(n_acc));
        n_acc++;
      end
      @(posedge clk); #1;
    end
    rd_valid[k] = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n_acc;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wr_valid[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0;
      rd_valid[k] = 1'b0; rd_addr[k] = '0; rsp_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset rsp_valid lane%0d", k), rsp_valid[k], 0);
      check($sformatf("reset wr_ready lane%0d", k), wr_ready[k], 0);
      check($sformatf("reset rd_ready lane%0d", k), rd_ready[k], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: MODE=2, RD_REG=0 write 0xA5 @0x3FE, read it back next cycle.
    wr_valid[0] = 1'b1; wr_addr[0] = 10'h3FE; wr_data[0] = 16'h12A5;
    rd_addr[0]  = 10'h3FE;
    @(negedge clk);
    check("t1 ram_wr_addr", ram_wr_addr[0], 8'hFF);
    check("t1 wr lane", ram_wr_data[0][17:16], 2'd2);
    check("t1 we", ram_wr_data[0][20], 1'b1);
    check("t1 wr data", ram_wr_data[0][15:0], 16'h00A5);
    check("t1 ram_rd_addr", ram_rd_addr[0], 8'hFF);
    check("t1 rd lane", ram_wr_data[0][25:24], 2'd2);
    @(posedge clk); #1;
    wr_valid[0] = 1'b0;
    do_read(0, 10'h3FE, 16'h00A5);
    expect_first_rsp(0, 2, "t1");
    drain(0, "t1");

    // T2: MODE=1, RD_REG=1 back-to-back reads in order.
    do_write(1, 10'h001, 16'h1234);
    do_write(1, 10'h000, 16'hBEEF);
    do_read(1, 10'h000, 16'hBEEF);
    do_read(1, 10'h001, 16'h1234);
    drain(1, "t2");
    // Address bit 9 is ignored in MODE=1; latency RD_REG+2.
    do_read(1, 10'h201, 16'h1234);
    expect_first_rsp(1, 3, "t2 lat");
    drain(1, "t2 lat");

    // T3: backpressure with 6 reads against 4 credits.
    for (int i = 0; i < 6; i++) do_write(0, 10'h100 + 10'(i), 16'h0060 + 16'(i));
    rsp_ready[0] = 1'b0;
    n_acc = 0;
    stream_reads(0, 10, 10'h100, 16'h0060, n_acc, 6);
    check("t3 accepted while stalled", n_acc, 4);
    rd_valid[0] = 1'b1; rd_addr[0] = 10'h104;
    @(negedge clk);
    check("t3 rd_ready low when full", rd_ready[0], 0);
    check("t3 head held", rsp_data[0], 16'h0060);
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    stream_reads(0, 20, 10'h100, 16'h0060, n_acc, 6);
    check("t3 all accepted", n_acc, 6);
    drain(0, "t3");

    // T6: push and pop in the same cycle with 3 stored entries.
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) do_read(0, 10'h100 + 10'(i), 16'h0060 + 16'(i));
    rsp_ready[0] = 1'b1;   // pop lands on the edge that stores the 4th read
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    n_acc = 0;
    stream_reads(0, 6, 10'h104, 16'h0064, n_acc, 6);
    check("t6 credits after push+pop", n_acc, 1);
    rsp_ready[0] = 1'b1;
    drain(0, "t6");

    // T4: write/read collision on 0x010.
    do_write(0, 10'h010, 16'h0011);
    wr_valid[0] = 1'b1; wr_addr[0] = 10'h010; wr_data[0] = 16'h005A;
    rd_valid[0] = 1'b1; rd_addr[0] = 10'h010;
    @(negedge clk);
    check("t4 wr_ready", wr_ready[0], 1);
`ifdef BRAM_WR_BYPASS_EN
    check("t4 rd_ready same cycle", rd_ready[0], 1);
    sb_push(0, 16'h005A);
    @(posedge clk); #1;
    wr_valid[0] = 1'b0; rd_valid[0] = 1'b0;
`else
    check("t4 rd_ready stalled", rd_ready[0], 0);
    @(posedge clk); #1;
    wr_valid[0] = 1'b0;
    @(negedge clk);
    check("t4 rd_ready next cycle", rd_ready[0], 1);
    sb_push(0, 16'h005A);
    @(posedge clk); #1;
    rd_valid[0] = 1'b0;
`endif
    drain(0, "t4");

    // T5: reset one cycle after two reads are accepted (lane 1).
    do_read(1, 10'h000, 16'hBEEF);
    do_read(1, 10'h001, 16'h1234);
    rst = 1'b1;
    exq1.delete();
    wr_valid[1] = 1'b1; wr_addr[1] = 10'h002; wr_data[1] = 16'h7777;
    rd_valid[1] = 1'b1; rd_addr[1] = 10'h000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t5 we in reset", ram_wr_data[1][20], 1'b0);
      check("t5 wr_ready in reset", wr_ready[1], 0);
      check("t5 rd_ready in reset", rd_ready[1], 0);
      check("t5 rsp_valid in reset", rsp_valid[1], 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    wr_valid[1] = 1'b0; rd_valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("t5 no rsp after reset c%0d", c), rsp_valid[1], 0);
      @(posedge clk); #1;
    end
    do_read(1, 10'h000, 16'hBEEF);
    expect_first_rsp(1, 3, "t5 post");
    drain(1, "t5 post");

    check("no fifo overflow", overflow_seen, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
